// File: rtl/apb_master.sv
// Single-outstanding APB requester: valid/ready command in, APB SETUP/ACCESS out, one registered response per command.
// Optional ACCESS wait-state timeout is enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pslverr
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t state_r;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_master: TIMEOUT_CYCLES must be at least 1");
  end

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_r;
`endif

  // Transfer sequencer: every bus and response output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cmd_ready <= 1'b1;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= {ADDR_WIDTH{1'b0}};
      pwdata    <= {DATA_WIDTH{1'b0}};
      rsp_valid <= 1'b0;
      rsp_rdata <= {DATA_WIDTH{1'b0}};
      rsp_err   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      wait_cnt_r <= {CNT_W{1'b0}};
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            pwrite    <= cmd_write;
            paddr     <= cmd_addr;
            pwdata    <= cmd_wdata;
            psel      <= 1'b1;
            cmd_ready <= 1'b0;
            state_r   <= ST_SETUP;
          end else begin
            state_r   <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          penable <= 1'b1;
          state_r <= ST_ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
          wait_cnt_r <= {CNT_W{1'b0}};
`endif
        end
        ST_ACCESS: begin
          // A completion on the same edge as the timeout limit takes priority.
          if (pready) begin
            rsp_valid <= 1'b1;
            rsp_err   <= pslverr;
            rsp_rdata <= (!pwrite && !pslverr) ? prdata : {DATA_WIDTH{1'b0}};
            psel      <= 1'b0;
            penable   <= 1'b0;
            cmd_ready <= 1'b1;
            state_r   <= ST_IDLE;
          end
`ifdef APB_MASTER_TIMEOUT_EN
          else if (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= {DATA_WIDTH{1'b0}};
            psel      <= 1'b0;
            penable   <= 1'b0;
            cmd_ready <= 1'b1;
            state_r   <= ST_IDLE;
          end else begin
            wait_cnt_r <= wait_cnt_r + CNT_W'(1);
            state_r    <= ST_ACCESS;
          end
`else
          else begin
            state_r <= ST_ACCESS;
          end
`endif
        end
        default: begin
          psel      <= 1'b0;
          penable   <= 1'b0;
          cmd_ready <= 1'b1;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
